ex_div: RTL and testbench
=========================

Name: ex_div

Overview:
- Multi-cycle integer divider in the execute stage.
- Consumes the ALU op and operand fields registered by the ID/EX pipeline register.
- Drives a stall request back to the pipeline controller. That request freezes IF/ID/EX while the division runs, so the ID/EX register keeps presenting the same op.
- Returns a 64-bit {remainder, quotient} result to the EX result mux, which writes HI/LO.

Parameters:
- OP_DIV, 8'b00011010, aluop code for signed divide.
- OP_DIVU, 8'b00011011, aluop code for unsigned divide.
- ITER, 32, number of quotient bits / BUSY cycles; equals operand width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_aluop  in  8  operation from ID/EX register.
- ex_reg1  in  32  dividend.
- ex_reg2  in  32  divisor.
- annul  in  1  flush of the current EX instruction (exception/branch kill).
- stallreq  out  1  request to freeze stages up to and including EX.
- ready  out  1  one-cycle pulse: result valid.
- result  out  64  [63:32] remainder (HI), [31:0] quotient (LO).

Behaviour:
- start = (ex_aluop==OP_DIV || ex_aluop==OP_DIVU) && !annul.
- Reset (rst low, asynchronous): state=IDLE, result=0, ready=0, counter=0, working registers=0. stallreq is forced 0 while rst is low.
- stallreq is combinational: start && state!=DONE. It is 0 in DONE so the pipeline advances in the completion cycle.
- State IDLE:
  - No start: stay in IDLE.
  - Start with ex_reg2==0: go to DONE next cycle; result is 0.
  - Start with ex_reg2!=0: latch operands and the signed flag, clear the counter, go to BUSY.
- State BUSY, restoring shift-subtract:
  - One quotient bit per cycle, ITER cycles.
  - Signed op: operate on magnitudes (two's-complement abs). 0x80000000 is handled as an unsigned magnitude 2^31.
  - Counter reaches ITER-1: go to DONE.
  - annul or !start during BUSY: abort to IDLE next cycle. result and ready stay unchanged; no pulse.
- State DONE:
  - Lasts exactly one cycle.
  - ready=1 and result is registered, with sign fix-up applied for signed ops:
    - quotient is negated if the operand signs differ;
    - remainder takes the sign of the dividend.
  - Next state is always IDLE. A new div presented the following cycle starts a fresh operation.
- Latency: start first seen in cycle N.
  - Nonzero divisor: BUSY N+1..N+32, ready in cycle N+33.
  - Zero divisor: ready in cycle N+1.
- result holds its last value until the next DONE.
- ready is 0 outside DONE.
- Operand changes during BUSY are ignored (operands are latched). The pipeline holds them anyway.
- A non-div aluop during IDLE or DONE has no effect.
- Reset mid-operation: immediate return to IDLE; no ready pulse.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0 (wraps, no trap).

Test Plan:
- DIVU, 100 / 7 -> stallreq=1 for cycles N..N+32; ready at N+33 with result={32'd2, 32'd14}; stallreq=0 in that cycle.
- DIV, -7 / 2 (0xFFFFFFF9 / 0x00000002) -> ready at N+33, quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- DIVU with divisor 0, dividend 0x1234 -> stallreq=1 only in cycle N; ready at N+1, result=0.
- DIVU 0xFFFFFFFF / 1 with annul asserted at BUSY cycle 10 -> stallreq drops the same cycle, IDLE next cycle, no ready pulse, result keeps its previous value.
- Two back-to-back DIVU ops (50/5, then 9/4) -> first ready at N+33 (quotient 10, remainder 0); second starts at N+34, ready at N+67 (quotient 2, remainder 1).
- rst pulled low at BUSY cycle 5, released 2 cycles later with aluop=NOP -> state IDLE, stallreq=0, ready=0, result=0.

Source files
------------

// File: rtl/ex_div.sv
// Multi-cycle restoring divider for the execute stage; stalls the pipeline while busy
// and returns {remainder, quotient} with a one-cycle ready pulse.
//
// state | meaning
// IDLE  | waiting for a div op from ID/EX
// BUSY  | shift-subtract, one quotient bit per cycle
// DONE  | result registered, ready pulse, pipeline released
module ex_div #(
  parameter logic [7:0] OP_DIV  = 8'b00011010,
  parameter logic [7:0] OP_DIVU = 8'b00011011,
  parameter int         ITER    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_reg1,
  input  logic [31:0] ex_reg2,
  input  logic        annul,
  output logic        stallreq,
  output logic        ready,
  output logic [63:0] result
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int            CW   = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   dvd;
  logic [31:0]   dsr;
  logic [31:0]   rem;
  logic          neg_q;
  logic          neg_r;

  logic          start;
  logic          is_signed;
  logic [31:0]   abs1;
  logic [31:0]   abs2;
  logic [32:0]   shifted;
  logic          q_bit;
  logic [31:0]   rem_step;
  logic [31:0]   dvd_step;
  logic [31:0]   q_fix;
  logic [31:0]   r_fix;

  assign start     = ((ex_aluop == OP_DIV) || (ex_aluop == OP_DIVU)) && !annul;
  assign is_signed = (ex_aluop == OP_DIV);
  assign stallreq  = rst && start && (state != ST_DONE);

  // 0x80000000 negates to itself, which is exactly its unsigned magnitude 2^31
  assign abs1 = (is_signed && ex_reg1[31]) ? -ex_reg1 : ex_reg1;
  assign abs2 = (is_signed && ex_reg2[31]) ? -ex_reg2 : ex_reg2;

  always_comb begin
    shifted  = {rem, dvd[31]};
    q_bit    = (shifted >= {1'b0, dsr});
    rem_step = q_bit ? (shifted[31:0] - dsr) : shifted[31:0];
    dvd_step = {dvd[30:0], q_bit};
    q_fix    = neg_q ? -dvd_step : dvd_step;
    r_fix    = neg_r ? -rem_step : rem_step;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      dvd    <= '0;
      dsr    <= '0;
      rem    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      ready  <= 1'b0;
      result <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (ex_reg2 == 32'd0) begin
              state  <= ST_DONE;
              ready  <= 1'b1;
              result <= '0;
            end else begin
              state <= ST_BUSY;
              cnt   <= '0;
              dvd   <= abs1;
              dsr   <= abs2;
              rem   <= '0;
              neg_q <= is_signed && (ex_reg1[31] ^ ex_reg2[31]);
              neg_r <= is_signed && ex_reg1[31];
            end
          end
        end
        ST_BUSY: begin
          if (!start) begin
            state <= ST_IDLE;
          end else begin
            dvd <= dvd_step;
            rem <= rem_step;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state  <= ST_DONE;
              ready  <= 1'b1;
              result <= {r_fix, q_fix};
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: vector table of divisions plus annul, back-to-back
// and mid-operation reset sequences.
module tb_ex_div;
  localparam logic [7:0] OP_DIV  = 8'b00011010;
  localparam logic [7:0] OP_DIVU = 8'b00011011;
  localparam logic [7:0] OP_NOP  = 8'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ex_aluop = OP_NOP;
  logic [31:0] ex_reg1 = '0;
  logic [31:0] ex_reg2 = '0;
  logic        annul = 1'b0;
  logic        stallreq;
  logic        ready;
  logic [63:0] result;

  always #5 clk = ~clk;

  ex_div dut (
    .clk(clk), .rst(rst), .ex_aluop(ex_aluop), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
    .annul(annul), .stallreq(stallreq), .ready(ready), .result(result)
  );

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents the op in cycle N, scrambles the operand buses while busy, and
  // measures cycles until ready.
  task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
    int   lat = 0;
    logic seen = 1'b0;
    logic stall_rdy = 1'b1;
    logic busy_ok = 1'b1;
    step();
    ex_aluop = op; ex_reg1 = a; ex_reg2 = b; annul = 1'b0;
    #1;
    chk({name, " stall@N"}, {63'd0, stallreq}, 64'd1);
    for (int k = 1; k <= 40; k++) begin
      step();
      ex_reg1 = ~a; ex_reg2 = 32'h5;
      #1;
      if (ready) begin
        seen = 1'b1; lat = k; stall_rdy = stallreq;
        break;
      end
      if (!stallreq) busy_ok = 1'b0;
    end
    chk({name, " ready seen (timeout)"}, {63'd0, seen}, 64'd1);
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " stall@ready"}, {63'd0, stall_rdy}, 64'd0);
    chk({name, " stall while busy"}, {63'd0, busy_ok}, 64'd1);
    chk({name, " result"}, result, exp_res);
  endtask

  task automatic quiet(input string name, input logic [63:0] exp_res);
    int pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step(); #1;
      if (ready || stallreq) pulses++;
    end
    chk({name, " no ready/stall while idle"}, 64'(pulses), 64'd0);
    chk({name, " result held"}, result, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] prev;

    vecs[0]  = '{"divu 100/7",        OP_DIVU, 32'd100,        32'd7,          33, 32'd14,         32'd2};
    vecs[1]  = '{"div -7/2",          OP_DIV,  32'hFFFFFFF9,   32'd2,          33, 32'hFFFFFFFD,   32'hFFFFFFFF};
    vecs[2]  = '{"div 7/-2",          OP_DIV,  32'd7,          32'hFFFFFFFE,   33, 32'hFFFFFFFD,   32'd1};
    vecs[3]  = '{"divu 0x1234/0",     OP_DIVU, 32'h1234,       32'd0,          1,  32'd0,          32'd0};
    vecs[4]  = '{"div ovf",           OP_DIV,  32'h80000000,   32'hFFFFFFFF,   33, 32'h80000000,   32'd0};
    vecs[5]  = '{"divu 50/5",         OP_DIVU, 32'd50,         32'd5,          33, 32'd10,         32'd0};
    vecs[6]  = '{"divu 9/4 b2b",      OP_DIVU, 32'd9,          32'd4,          33, 32'd2,          32'd1};
    vecs[7]  = '{"div -100/-7",       OP_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   33, 32'd14,         32'hFFFFFFFE};
    vecs[8]  = '{"divu max/1",        OP_DIVU, 32'hFFFFFFFF,   32'd1,          33, 32'hFFFFFFFF,   32'd0};
    vecs[9]  = '{"divu max/2^31",     OP_DIVU, 32'hFFFFFFFF,   32'h80000000,   33, 32'd1,          32'h7FFFFFFF};
    vecs[10] = '{"div -2^31/2",       OP_DIV,  32'h80000000,   32'd2,          33, 32'hC0000000,   32'd0};
    vecs[11] = '{"divu 3/10",         OP_DIVU, 32'd3,          32'd10,         33, 32'd0,          32'd3};

    // reset: stallreq forced low even with a div op presented
    ex_aluop = OP_DIVU; ex_reg1 = 32'd10; ex_reg2 = 32'd2;
    #2 rst = 1'b0;
    #1;
    chk("reset stallreq", {63'd0, stallreq}, 64'd0);
    chk("reset ready", {63'd0, ready}, 64'd0);
    chk("reset result", result, 64'd0);
    ex_aluop = OP_NOP;
    step(); step();
    rst = 1'b1;
    #1;
    chk("post-reset stallreq", {63'd0, stallreq}, 64'd0);

    // consecutive calls are back-to-back: each new op lands the cycle after DONE
    for (int i = 0; i < 12; i++)
      run_div(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, {vecs[i].r, vecs[i].q});
    prev = {vecs[11].r, vecs[11].q};

    // annul at BUSY cycle 10
    step();
    ex_aluop = OP_DIVU; ex_reg1 = 32'hFFFFFFFF; ex_reg2 = 32'd1; annul = 1'b0;
    #1;
    chk("annul stall@N", {63'd0, stallreq}, 64'd1);
    for (int k = 1; k <= 9; k++) step();
    step();
    annul = 1'b1;
    #1;
    chk("annul stall drop", {63'd0, stallreq}, 64'd0);
    chk("annul ready", {63'd0, ready}, 64'd0);
    step();
    annul = 1'b0; ex_aluop = OP_NOP;
    #1;
    chk("annul next ready", {63'd0, ready}, 64'd0);
    chk("annul next result", result, prev);
    quiet("annul", prev);
    run_div("divu 100/7 after annul", OP_DIVU, 32'd100, 32'd7, 33, {32'd2, 32'd14});
    prev = {32'd2, 32'd14};

    // reset at BUSY cycle 5
    step();
    ex_aluop = OP_DIVU; ex_reg1 = 32'hFFFFFFFF; ex_reg2 = 32'd1;
    #1;
    chk("rst stall@N", {63'd0, stallreq}, 64'd1);
    for (int k = 1; k <= 4; k++) step();
    step();
    rst = 1'b0;
    #1;
    chk("rst mid stallreq", {63'd0, stallreq}, 64'd0);
    chk("rst mid ready", {63'd0, ready}, 64'd0);
    chk("rst mid result", result, 64'd0);
    step(); step();
    rst = 1'b1; ex_aluop = OP_NOP;
    #1;
    chk("rst release stallreq", {63'd0, stallreq}, 64'd0);
    chk("rst release ready", {63'd0, ready}, 64'd0);
    chk("rst release result", result, 64'd0);
    quiet("after rst", 64'd0);
    run_div("div -100/7 after rst", OP_DIV, 32'hFFFFFF9C, 32'd7, 33, {32'hFFFFFFFE, 32'hFFFFFFF2});

    step();
    ex_aluop = OP_NOP;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
